// File: rtl/reset_seq_pkg.sv
// Shared encodings for the staged reset sequencer: FSM states, reset cause
// codes and a small elaboration-time helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer (master) and the
// top-level reset domains plus software/watchdog sources (slave).
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  sw_reset_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic                  wdt_kick;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  busy;
    logic                  sys_ready;
    logic [1:0]            reset_cause;
    logic [NUM_STAGES-1:0] ack_err;

    modport master (
        input  sw_reset_req, stage_ack, wdt_kick,
        output stage_reset, busy, sys_ready, reset_cause, ack_err
    );

    modport slave (
        output sw_reset_req, stage_ack, wdt_kick,
        input  stage_reset, busy, sys_ready, reset_cause, ack_err
    );
endinterface

// File: rtl/reset_hold_counter.sv
// Saturating up-counter with synchronous clear and enable; tc is high once
// the count has reached the (runtime) limit.
module reset_hold_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q < limit)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q >= limit);
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains, then releases them in order
// with a hold time and ack handshake. Watchdog built only with RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int WDT_CYCLES  = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, ACK_TIMEOUT) + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
    // Wait phase starts one cycle after saturation, so it needs one count less.
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(ACK_TIMEOUT - 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t                state_q, state_d;
    cause_t                cause_q, cause_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  waiting_q, waiting_d;
    logic                  started_q;
    logic [NUM_STAGES-1:0] ack_err_q, ack_err_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  busy_q, sys_ready_q;
    logic                  cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0]      cnt_lim;
    logic                  wdt_fire;

    reset_hold_counter #(.W(CNT_W)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_lim),
        .tc    (cnt_tc)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    logic wdt_tc;

    reset_hold_counter #(.W(WDT_W)) u_wdt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q != ST_RUN) || bus.wdt_kick),
        .en    (1'b1),
        .limit (WDT_W'(WDT_CYCLES - 1)),
        .tc    (wdt_tc)
    );

    assign wdt_fire = (state_q == ST_RUN) && wdt_tc && !bus.wdt_kick;
`else
    logic unused_wdt;
    assign unused_wdt = bus.wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_fire   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        waiting_d     = waiting_q;
        cause_d       = cause_q;
        ack_err_d     = ack_err_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        cnt_lim       = HOLD_LIM;
        stage_reset_d = '1;

        if (bus.sw_reset_req || wdt_fire) begin
            state_d   = ST_ASSERT;
            idx_d     = '0;
            waiting_d = 1'b0;
            cnt_clr   = 1'b1;
            cause_d   = bus.sw_reset_req ? CAUSE_SW : CAUSE_WDT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    // The first edge after reset release only arms the counter.
                    cnt_en = started_q;
                    if (cnt_tc) begin
                        state_d = ST_RELEASE;
                        idx_d   = '0;
                        cnt_clr = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    cnt_en  = 1'b1;
                    cnt_lim = waiting_q ? WAIT_LIM : HOLD_LIM;
                    if ((cnt_tc || waiting_q) &&
                        (bus.stage_ack[idx_q] || (waiting_q && cnt_tc))) begin
                        if (!bus.stage_ack[idx_q]) begin
                            ack_err_d[idx_q] = 1'b1;
                        end
                        waiting_d = 1'b0;
                        cnt_clr   = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (cnt_tc && !waiting_q) begin
                        waiting_d = 1'b1;
                        cnt_clr   = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_clr = 1'b1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_clr = 1'b1;
                end
            endcase
        end

        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_reset_d[i] = !((state_d == ST_RUN) ||
                                 ((state_d == ST_RELEASE) && (IDX_W'(i) <= idx_d)));
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ASSERT;
            idx_q         <= '0;
            waiting_q     <= 1'b0;
            started_q     <= 1'b0;
            cause_q       <= CAUSE_POR;
            ack_err_q     <= '0;
            stage_reset_q <= '1;
            busy_q        <= 1'b1;
            sys_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            waiting_q     <= waiting_d;
            started_q     <= 1'b1;
            cause_q       <= cause_d;
            ack_err_q     <= ack_err_d;
            stage_reset_q <= stage_reset_d;
            busy_q        <= (state_d != ST_RUN);
            sys_ready_q   <= (state_d == ST_RUN);
        end
    end

    assign bus.stage_reset = stage_reset_q;
    assign bus.busy        = busy_q;
    assign bus.sys_ready   = sys_ready_q;
    assign bus.reset_cause = cause_q;
    assign bus.ack_err     = ack_err_q;
endmodule
